// File: rtl/reg_file_ctrl_if.sv
// Request/response bundle between a requester (datapath or sequencer) and the
// register file access controller.
interface reg_file_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr_a;
    logic [AW-1:0] req_addr_b;
    logic [DW-1:0] req_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    // Requester side: issues ops and accepts responses.
    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Controller side: accepts ops and returns responses.
    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// Access controller for a small register file with a one-cycle registered read.
// Serializes READ / WRITE / MOVE ops, drives the file's address, one-hot write
// enables and write data, and returns one response per op.
module reg_file_ctrl #(
    parameter  int DW = 8,
    parameter  int AW = 2,
    localparam int NR = 2 ** AW
) (
    input  logic             clk,
    input  logic             rstn,
    reg_file_ctrl_if.slave   bus,
    output logic [AW-1:0]    rf_addr,
    output logic [NR-1:0]    rf_ce,
    output logic [DW-1:0]    rf_wdata,
    input  logic [DW-1:0]    rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR,
        RSP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSV   = 2'b11
    } op_t;

    state_t        state, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] rf_addr_d;
    logic [NR-1:0] rf_ce_d;
    logic [DW-1:0] rf_wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    function automatic logic [NR-1:0] onehot(input logic [AW-1:0] idx);
        logic [NR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Ready depends on state alone, so there is no path from req_valid.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Next-state and next-output decode for every registered signal.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latch).
        state_d    = state;
        op_d       = op_q;
        dst_d      = dst_q;
        rf_addr_d  = rf_addr;
        rf_ce_d    = '0;
        rf_wdata_d = rf_wdata;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d  = op_t'(bus.req_op);
                    dst_d = bus.req_addr_b;
                    case (op_t'(bus.req_op))
                        OP_READ, OP_MOVE: begin
                            rf_addr_d = bus.req_addr_a;
                            state_d   = RD1;
                        end
                        OP_WRITE: begin
                            rf_ce_d    = onehot(bus.req_addr_a);
                            rf_wdata_d = bus.req_data;
                            state_d    = WR;
                        end
                        default: begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                            state_d    = RSP;
                        end
                    endcase
                end
            end
            // The file samples rf_addr at the end of this cycle.
            RD1: state_d = RD2;
            RD2: begin
                rsp_data_d = rf_rdata;
                if (op_q == OP_MOVE) begin
                    rf_ce_d    = onehot(dst_q);
                    rf_wdata_d = rf_rdata;
                    state_d    = WR;
                end else begin
                    state_d = RSP;
                end
            end
            // rf_ce is high for this one cycle only; the response echoes the written value.
            WR: begin
                rsp_data_d = rf_wdata;
                state_d    = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RSP);
    end

    // State and registered outputs; reset drops any op in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            dst_q       <= '0;
            rf_addr     <= '0;
            rf_ce       <= '0;
            rf_wdata    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state       <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            rf_addr     <= rf_addr_d;
            rf_ce       <= rf_ce_d;
            rf_wdata    <= rf_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: a behavioural 4x8 register file with registered
// read, directed scenarios, then random ops against an array reference model.
module tb_reg_file_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] rf_addr;
    logic [NR-1:0] rf_ce;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    logic [DW-1:0] rf_mem  [NR];
    int            ref_mem [NR];

    int errors = 0;
    int checks = 0;

    reg_file_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    reg_file_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .rf_addr  (rf_addr),
        .rf_ce    (rf_ce),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file: write on any enabled bit, one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (rf_ce[i]) rf_mem[i] <= rf_wdata;
        rf_rdata <= rf_mem[rf_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One op from the requester's view, checked against the reference model.
    // stall = number of response cycles with rsp_ready low before acceptance.
    task automatic do_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [7:0] d, input int stall);
        int         exp_lat;
        int         exp_data;
        int         exp_err;
        int         exp_ce;
        int         exp_ce_cycles;
        int         k;
        int         ce_cycles;
        int         ce_at;
        bit         seen;
        logic [7:0] held;

        exp_err       = 0;
        exp_ce        = 0;
        exp_ce_cycles = 0;
        case (op)
            2'b00: begin exp_lat = 3; exp_data = ref_mem[a]; end
            2'b01: begin
                exp_lat = 2; exp_data = d; exp_ce = 1 << a; exp_ce_cycles = 1;
                ref_mem[a] = d;
            end
            2'b10: begin
                exp_lat = 4; exp_data = ref_mem[a]; exp_ce = 1 << b; exp_ce_cycles = 1;
                ref_mem[b] = ref_mem[a];
            end
            default: begin exp_lat = 1; exp_data = 0; exp_err = 1; end
        endcase

        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.req_data   = d;
        bus.rsp_ready  = (stall == 0);
        @(negedge clk);
        check("req_ready_c0", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'($urandom);
        bus.req_addr_a = 2'($urandom);
        bus.req_addr_b = 2'($urandom);
        bus.req_data   = 8'($urandom);

        k = 0; ce_cycles = 0; ce_at = -1; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            check("ce_onehot", ($countones(rf_ce) <= 1), 1);
            if (rf_ce != 0) begin
                ce_cycles++;
                ce_at = k;
                check("ce_value", rf_ce, exp_ce);
                check("wdata", rf_wdata, exp_data);
            end
            if ((op == 2'b00 || op == 2'b10) && (k == 1 || k == 2))
                check("rf_addr_rd", rf_addr, a);
            if (bus.rsp_valid) seen = 1;
        end
        check("rsp_seen", seen, 1);
        check("latency", k, exp_lat);
        check("ce_cycles", ce_cycles, exp_ce_cycles);
        if (exp_ce_cycles == 1) check("ce_cycle_pos", ce_at, exp_lat - 1);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, exp_err);
        check("req_ready_rsp", bus.req_ready, 0);
        held = bus.rsp_data;

        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            bus.req_valid = (s == 2);
            if (s == stall) bus.rsp_ready = 1'b1;
            @(negedge clk);
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_data", bus.rsp_data, held);
            check("stall_err", bus.rsp_err, exp_err);
            check("stall_ready", bus.req_ready, 0);
            check("stall_ce", rf_ce, 0);
        end

        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_rsp_err", bus.rsp_err, 0);
        check("post_req_ready", bus.req_ready, 1);
        for (int i = 0; i < NR; i++)
            check("rf_contents", rf_mem[i], ref_mem[i]);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rf_mem[i]  = '0;
            ref_mem[i] = 0;
        end
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_addr_a = '0;
        bus.req_addr_b = '0;
        bus.req_data   = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state.
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_ce", rf_ce, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_req_ready", bus.req_ready, 1);
        rstn = 1'b1;

        // Directed sequence.
        do_op(2'b01, 2'd2, 2'd0, 8'h5A, 0);  // WRITE r2 = 0x5A
        do_op(2'b00, 2'd2, 2'd0, 8'h00, 0);  // READ r2
        do_op(2'b10, 2'd2, 2'd1, 8'h00, 0);  // MOVE r2 -> r1
        do_op(2'b00, 2'd1, 2'd0, 8'h00, 0);  // READ r1
        do_op(2'b11, 2'd3, 2'd0, 8'hFF, 0);  // reserved op
        do_op(2'b00, 2'd2, 2'd0, 8'h00, 5);  // READ with stalled response
        do_op(2'b01, 2'd3, 2'd0, 8'hC3, 0);  // WRITE r3
        do_op(2'b10, 2'd3, 2'd3, 8'h00, 0);  // MOVE with A == B

        // Reset in RD2 of a MOVE r2 -> r0: no write to r0, no response.
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_op     = 2'b10;
        bus.req_addr_a = 2'd2;
        bus.req_addr_b = 2'd0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;   // accepted -> RD1
        bus.req_valid = 1'b0;
        @(posedge clk);       // -> RD2
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_rf_ce", rf_ce, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_no_write", rf_mem[0], ref_mem[0]);
        check("midrst_rsp_idle", bus.rsp_valid, 0);
        do_op(2'b01, 2'd0, 2'd0, 8'hA7, 0);  // next WRITE completes normally
        do_op(2'b00, 2'd0, 2'd0, 8'h00, 1);

        // Random ops against the reference model.
        for (int n = 0; n < 40; n++)
            do_op(2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom),
                  8'($urandom), int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Access controller that drives the 4x8 register file's write/read port: CE one-hot write enables, address, write data, and registered read data.
- Accepts single requests from the datapath or sequencer over a valid/ready handshake.
- Request ops: READ, WRITE, MOVE (register-to-register copy).
- Sequences each op around the file's one-cycle registered read latency and returns a result over a valid/ready response channel.

Parameters:
DW  8  data width; matches the register file word.
AW  2  register address width; register count is 2**AW, so RF_CE is 2**AW bits.

Ports:
CLK        in   1   clock, rising edge
RSTN       in   1   asynchronous active-low reset
REQ_VALID  in   1   request valid
REQ_READY  out  1   request ready; high only in IDLE
REQ_OP     in   2   00 READ, 01 WRITE, 10 MOVE, 11 reserved
REQ_ADDR_A in   AW  READ/WRITE target; MOVE source
REQ_ADDR_B in   AW  MOVE destination; ignored otherwise
REQ_DATA   in   DW  WRITE data
RSP_VALID  out  1   response valid
RSP_READY  in   1   response accept
RSP_DATA   out  DW  read data, or the value written
RSP_ERR    out  1   high with RSP_VALID for a reserved op
RF_ADDR    out  AW  register file read address
RF_CE      out  2**AW  register file one-hot write enables
RF_WDATA   out  DW  register file write data
RF_RDATA   in   DW  register file registered read data

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, mid-operation included. The in-flight op is dropped with no response.
  - State goes to IDLE. RF_ADDR=0, RF_CE=0, RF_WDATA=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0. REQ_READY=1 (state is IDLE).
- Outputs:
  - All RF_* and RSP_* outputs are registered.
  - REQ_READY is decoded from state only: (state==IDLE). No combinational path from REQ_VALID.
- FSM states: IDLE, RD1, RD2, WR, RSP. Cycle c0 is the accept cycle (REQ_VALID & REQ_READY); op, A, B and data are latched at the end of c0.
- IDLE transitions:
  - READ or MOVE: RF_ADDR<=A, go to RD1.
  - WRITE: RF_CE<=onehot(A), RF_WDATA<=REQ_DATA, go to RD... no: go to WR.
  - Reserved op: RSP_ERR<=1, RSP_DATA<=0, go to RSP.
- RD1: RF_ADDR is held. The file samples its address at the end of this cycle. Go to RD2.
- RD2: RF_RDATA is valid.
  - READ: RSP_DATA<=RF_RDATA, go to RSP.
  - MOVE: RF_CE<=onehot(B), RF_WDATA<=RF_RDATA, RSP_DATA<=RF_RDATA, go to WR.
- WR: RF_CE is high for exactly this one cycle, and the file writes at its end. Next: RF_CE<=0, RSP_DATA<=RF_WDATA, go to RSP.
- RSP: RSP_VALID=1, with RSP_DATA and RSP_ERR held stable until RSP_READY. On handshake: RSP_VALID<=0, RSP_ERR<=0, go to IDLE.
- Latency from c0 to first RSP_VALID cycle:
  - READ: 3 cycles
  - WRITE: 2 cycles
  - MOVE: 4 cycles
  - reserved: 1 cycle
- Throughput: one op in flight. The next accept is the cycle after the response handshake.
- RF_CE is always one-hot or zero; never more than one bit set. It is zero in every state except WR.
- RF_ADDR holds its last value outside RD1/RD2, which is harmless.
- MOVE with A==B: full read-then-write sequence, register value unchanged.
- RF_RDATA is sampled only in RD2. Read-after-write hazards are impossible because ops are serialized.
- RSP_READY held high in RSP: single-cycle RSP_VALID. RSP_READY low: RSP holds indefinitely and REQ_READY stays 0.
- REQ_* inputs are ignored outside IDLE.

Test Plan:
- Reset then WRITE A=2 DATA=0x5A, RSP_READY=1 -> RF_CE=0100 for exactly 1 cycle with RF_WDATA=0x5A; RSP_VALID on cycle c0+2 with RSP_DATA=0x5A, RSP_ERR=0.
- Following READ A=2 -> RF_ADDR=2 in RD1/RD2; RSP_VALID at c0+3 with RSP_DATA=0x5A; RF_CE stays 0000 throughout.
- MOVE A=2 B=1 after the above -> RF_CE=0010 with RF_WDATA=0x5A in cycle c0+3; RSP_DATA=0x5A at c0+4; a subsequent READ A=1 returns 0x5A.
- REQ_OP=11 -> RSP_VALID at c0+1 with RSP_ERR=1, RSP_DATA=0x00; RF_CE never asserted.
- RSP_READY held low 5 cycles after a READ -> RSP_VALID and RSP_DATA stable for all 5; REQ_READY=0; a REQ_VALID pulse in that window is not accepted.
- RSTN low during MOVE in RD2 -> RF_CE=0, RSP_VALID=0, REQ_READY=1 immediately; no write to B; next WRITE completes normally.
